// File: rtl/io_gpio_pkg.sv
// io_gpio shared definitions: register addresses, access-size encodings and write masks.
package io_gpio_pkg;

   localparam logic [31:0] IO_ADDR_SW       = 32'd1;
   localparam logic [31:0] IO_ADDR_BTN      = 32'd2;
   localparam logic [31:0] IO_ADDR_LED      = 32'd4;
   localparam logic [31:0] IO_ADDR_LED_SET  = 32'd5;
   localparam logic [31:0] IO_ADDR_LED_CLR  = 32'd6;
   localparam logic [31:0] IO_ADDR_BTN_EDGE = 32'd8;
   localparam logic [31:0] IO_ADDR_IRQ_EN   = 32'd9;

   localparam logic [2:0] IO_SIZE_BYTE = 3'd0;
   localparam logic [2:0] IO_SIZE_HALF = 3'd1;
   localparam logic [2:0] IO_SIZE_WORD = 3'd2;

   // Write-data mask for a bus access size; unknown encodings behave as word.
   function automatic logic [31:0] io_size_mask(input logic [2:0] size);
      case (size)
         IO_SIZE_BYTE: return 32'h0000_00FF;
         IO_SIZE_HALF: return 32'h0000_FFFF;
         IO_SIZE_WORD: return 32'hFFFF_FFFF;
         default:      return 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/io_debounce.sv
// Single-bit input conditioner: 2-flop synchroniser followed by a stable-count debouncer.
// The debouncer is present only when IO_GPIO_DEBOUNCE_EN is defined; otherwise the
// synchroniser output is passed straight through.
module io_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
      $error("io_debounce: DEBOUNCE_CYCLES must be at least 2");
   end

   // Synchroniser next state.
   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
   end

   // Synchroniser flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

`ifdef IO_GPIO_DEBOUNCE_EN
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;

   // Count consecutive disagreeing samples; adopt the new level on the terminal count.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Debounce state flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign dout = stable_q;
`else
   assign dout = sync2_q;
`endif

endmodule

// File: rtl/io_gpio.sv
// Memory-mapped GPIO controller: conditioned switch/button inputs, LED register with
// set/clear aliases, sticky button rising-edge flags and a level interrupt.
// Build option: IO_GPIO_DEBOUNCE_EN enables the per-bit debounce counters.
module io_gpio
   import io_gpio_pkg::*;
#(
   parameter int unsigned SW_W            = 16,
   parameter int unsigned BTN_W           = 5,
   parameter int unsigned LED_W           = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      io_address,
   input  logic [31:0]      io_write_value,
   input  logic             io_write_en,
   input  logic             io_read_en,
   input  logic [2:0]       io_data_size,
   output logic [31:0]      io_read_value,
   input  logic [SW_W-1:0]  sw_in,
   input  logic [BTN_W-1:0] btn_in,
   output logic [LED_W-1:0] led_out,
   output logic             irq
);

   logic [SW_W-1:0]  sw_db;
   logic [BTN_W-1:0] btn_db;

   logic [LED_W-1:0] led_q, led_d;
   logic [BTN_W-1:0] btn_prev_q, btn_prev_d;
   logic [BTN_W-1:0] btn_edge_q, btn_edge_d;
   logic [BTN_W-1:0] irq_en_q, irq_en_d;
   logic             irq_q, irq_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [31:0]      wdata_m;

   // Per-bit conditioning of the switch inputs.
   for (genvar i = 0; i < SW_W; i++) begin : g_sw
      io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (sw_in[i]),
         .dout  (sw_db[i])
      );
   end

   // Per-bit conditioning of the button inputs.
   for (genvar i = 0; i < BTN_W; i++) begin : g_btn
      io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (btn_in[i]),
         .dout  (btn_db[i])
      );
   end

   // Register writes, edge capture, interrupt and read mux; reads see pre-write state.
   always_comb begin
      wdata_m    = io_write_value & io_size_mask(io_data_size);
      led_d      = led_q;
      irq_en_d   = irq_en_q;
      btn_edge_d = btn_edge_q;
      btn_prev_d = btn_db;
      rdata_d    = rdata_q;

      if (io_write_en) begin
         case (io_address)
            IO_ADDR_LED:      led_d      = wdata_m[LED_W-1:0];
            IO_ADDR_LED_SET:  led_d      = led_q | wdata_m[LED_W-1:0];
            IO_ADDR_LED_CLR:  led_d      = led_q & ~wdata_m[LED_W-1:0];
            IO_ADDR_BTN_EDGE: btn_edge_d = btn_edge_q & ~wdata_m[BTN_W-1:0];
            IO_ADDR_IRQ_EN:   irq_en_d   = wdata_m[BTN_W-1:0];
            default:          ;
         endcase
      end

      // A new rising edge overrides a same-cycle clear.
      btn_edge_d = btn_edge_d | (btn_db & ~btn_prev_q);

      irq_d = |(btn_edge_q & irq_en_q);

      if (io_read_en) begin
         case (io_address)
            IO_ADDR_SW:       rdata_d = 32'(sw_db);
            IO_ADDR_BTN:      rdata_d = 32'(btn_db) << (16 - BTN_W);
            IO_ADDR_LED:      rdata_d = 32'(led_q);
            IO_ADDR_BTN_EDGE: rdata_d = 32'(btn_edge_q);
            IO_ADDR_IRQ_EN:   rdata_d = 32'(irq_en_q);
            default:          rdata_d = 32'd0;
         endcase
      end
   end

   // Architectural register flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q      <= '0;
         irq_en_q   <= '0;
         btn_edge_q <= '0;
         btn_prev_q <= '0;
         irq_q      <= 1'b0;
         rdata_q    <= 32'd0;
      end else begin
         led_q      <= led_d;
         irq_en_q   <= irq_en_d;
         btn_edge_q <= btn_edge_d;
         btn_prev_q <= btn_prev_d;
         irq_q      <= irq_d;
         rdata_q    <= rdata_d;
      end
   end

   assign led_out       = led_q;
   assign irq           = irq_q;
   assign io_read_value = rdata_q;

endmodule

// File: doc/io_gpio.md
# io_gpio

Parametrised memory-mapped GPIO controller on the Risc32 I/O bus (`io_address`, `io_write_value`, `io_read_value`, `io_write_en`, `io_read_en`, `io_data_size`). It replaces the ad-hoc switch/button/LED decode in the board top level. It adds input synchronisation, per-bit debounce, sticky button edge flags with interrupt, and LED set/clear registers. It keeps the existing addresses 1 (switches), 2 (buttons) and 4 (LEDs) binary-compatible.

## Interface
- `SW_W`, 16: switch inputs, 1..32.
- `BTN_W`, 5: button inputs, 1..16.
- `LED_W`, 16: LED outputs, 1..32.
- `DEBOUNCE_CYCLES`, 1000000: stable-sample count, ≥2 (10 ms at 100 MHz).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `io_address`  in  32  word register address.
- `io_write_value`  in  32  write data.
- `io_write_en`  in  1  write strobe, one cycle per access.
- `io_read_en`  in  1  read strobe, one cycle per access.
- `io_data_size`  in  3  access size: 0 byte, 1 half, 2 word, other values treated as word.
- `io_read_value`  out  32  registered read data.
- `sw_in`  in  SW_W  raw switches, asynchronous.
- `btn_in`  in  BTN_W  raw buttons, asynchronous.
- `led_out`  out  LED_W  LED register.
- `irq`  out  1  level interrupt.

## Operation
- **Input conditioning.** Every input bit passes through a 2-flop synchroniser and then a debouncer, producing `sw_db` and `btn_db`.
- **Register map** (full 32-bit address compare; unmapped reads return 0, unmapped writes are ignored):
  - 1 SW, RO: `sw_db`, zero-extended.
  - 2 BTN, RO: `btn_db` left-aligned at bit 15, i.e. bits [15:16-BTN_W]; all other bits 0.
  - 4 LED, RW: write replaces; read returns `led_out`.
  - 5 LED_SET, WO: `led |= data`.
  - 6 LED_CLR, WO: `led &= ~data`.
  - 8 BTN_EDGE, RW1C: sticky rising-edge flags, bit i = button i.
  - 9 IRQ_EN, RW: bits [BTN_W-1:0].
- **Write size masking.** The mask is applied to LED, LED_SET, LED_CLR, BTN_EDGE and IRQ_EN.
  - byte: bits [7:0] only.
  - half: bits [15:0] only.
  - word: all bits.
  - Bits beyond a register's width are dropped.
- **Edge flags.** A flag is set when its `btn_db` bit goes 0→1.
- **Interrupt.** `irq = |(btn_edge & irq_en)`, registered.

## Timing
- **Reset values:** `io_read_value`, `led_out`, `btn_edge`, `irq_en` and `irq` are 0. Synchroniser flops, debounce counters, `sw_db` and `btn_db` are 0.
- **Asynchronous reset mid-debounce:** the counter is discarded and the stable value returns to 0.
- **Read latency:** 1 cycle. `io_read_value` is valid the cycle after `io_read_en` and holds its value until the next read.
- **Write latency:** the register updates on the edge that samples `io_write_en`. A read in the following cycle returns the new value.
- **Simultaneous read and write strobes:** the read returns the pre-write value.
- **Debounce counter**, per bit:
  - Clears whenever the synchronised value equals the stable value.
  - Otherwise increments.
  - When it would reach DEBOUNCE_CYCLES, the stable value takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
  - Input-to-stable latency is exactly 2 + DEBOUNCE_CYCLES cycles.
- **Edge flag timing:** `btn_edge` sets 1 cycle after the `btn_db` rise; `irq` asserts 1 cycle after that.
- **Set/clear conflicts:**
  - An edge set and a W1C on the same bit in the same cycle: set wins.
  - LED_SET and LED_CLR cannot coincide (single bus).
- **Counter width:** `$clog2(DEBOUNCE_CYCLES+1)`. No wrap is possible because the counter clears at terminal count.

## Configuration
- `IO_GPIO_DEBOUNCE_EN` defined: debouncers instantiated as above.
- `IO_GPIO_DEBOUNCE_EN` undefined: `sw_db`/`btn_db` equal the synchroniser output directly. Input-to-stable latency is 2 cycles, no counters are instantiated, and DEBOUNCE_CYCLES is ignored. Edge and irq behaviour are unchanged.

## Structure
- **Package `io_gpio_pkg`:**
  - address constants: `IO_ADDR_SW`=1, `IO_ADDR_BTN`=2, `IO_ADDR_LED`=4, `IO_ADDR_LED_SET`=5, `IO_ADDR_LED_CLR`=6, `IO_ADDR_BTN_EDGE`=8, `IO_ADDR_IRQ_EN`=9.
  - size encodings: `IO_SIZE_BYTE`, `IO_SIZE_HALF`, `IO_SIZE_WORD`.
  - function `io_size_mask(size)` returning the 32-bit mask.
- **Sub-module `io_debounce`:** one bit, synchroniser plus counter, parameter DEBOUNCE_CYCLES. Instantiated SW_W+BTN_W times via generate.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 with the macro defined, unless stated otherwise.
1. Reset low mid-run → all outputs 0. Release reset, read addr 1 with `sw_in`=0 → `io_read_value`=0 one cycle later.
2. `sw_in`=16'hA5C3 held 6 cycles, then read addr 1 → 32'h0000A5C3. A 3-cycle pulse on `sw_in[0]` → read stays 0.
3. Write addr 4 word 32'h00FF; write addr 5 byte 32'h0000_0F00 → `led_out`=16'h00FF (byte mask drops bits above 7). Write addr 6 half 32'h000F → `led_out`=16'h00F0.
4. Write IRQ_EN=5'b00100, press `btn_in[2]` → read addr 2 returns 32'h00002000. `irq` rises exactly 8 cycles after the press. Write addr 8 with 32'h4 → `irq` falls, flag 0.
5. Button rise coincides with a W1C of the same bit → flag remains 1.
6. Macro undefined: `sw_in` change visible in a read issued 2 cycles later; a 1-cycle glitch propagates.
